// File: rtl/shared_ram_pkg.sv
// Shared definitions for the shared scratch RAM: default widths, pointer
// width helper and flattened-bus slice helper.
package shared_ram_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 256;

    // Bits needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Low bit of lane idx inside a flattened bus of width-bit lanes.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/shared_ram_arbiter_if.sv
// Bus between the peripheral masters and the shared RAM arbiter.
interface shared_ram_arbiter_if
    import shared_ram_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
);
    // Handshake: master i raises req[i] with we/addr/wdata and holds them
    // stable until gnt[i]; the access happens on the rising edge where
    // req[i] & gnt[i]. Dropping req before gnt withdraws the request.
    // A read answers one cycle later with rvalid[i] and rdata; an
    // out-of-range access (read or write) answers with err[i] in that cycle.
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        gnt;
    logic [NUM_PORTS-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;
    logic [NUM_PORTS-1:0]        err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/shared_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter
    import shared_ram_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int PTR_W     = clog2_min1(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_advance,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic [PTR_W-1:0]     o_ptr
);

    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [PTR_W-1:0]     w_idx;
    logic [NUM_PORTS-1:0] w_gnt;
    logic                 w_found;

    // Search ptr, ptr+1, ... mod NUM_PORTS; first requester wins.
    always_comb begin
        w_gnt      = '0;
        w_next_ptr = r_ptr;
        w_idx      = '0;
        w_found    = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_idx = PTR_W'((int'(r_ptr) + j) % NUM_PORTS);
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                w_gnt[w_idx] = 1'b1;
                w_next_ptr   = PTR_W'((int'(r_ptr) + j + 1) % NUM_PORTS);
            end
        end
        if (!rst_n) begin
            w_gnt = '0;
        end
    end

    // Pointer register: moves past the winner, holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign o_gnt = w_gnt;
    assign o_ptr = r_ptr;

endmodule

// File: rtl/shared_ram_arbiter.sv
// Single-port scratch RAM shared by NUM_PORTS masters through a round-robin
// arbiter. One access per cycle, read data one cycle after the grant,
// out-of-range accesses flagged on err.
module shared_ram_arbiter
    import shared_ram_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    shared_ram_arbiter_if.slave                 bus,
    output logic [clog2_min1(NUM_PORTS)-1:0]    o_dbg_ptr
);

    localparam int              IDX_W     = clog2_min1(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [NUM_PORTS-1:0] w_gnt;
    logic                 w_any;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_in_range;
    logic [IDX_W-1:0]     w_idx;

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [DATA_W-1:0]    r_rdata;
    logic [NUM_PORTS-1:0] r_rvalid;
    logic [NUM_PORTS-1:0] r_err;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req),
        .i_advance (w_any),
        .o_gnt     (w_gnt),
        .o_ptr     (o_dbg_ptr)
    );

    assign w_any = |w_gnt;

    // Route the granted port's command onto the single RAM port.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt[i]) begin
                w_sel_we    = bus.we[i];
                w_sel_addr  = bus.addr[slice_lo(i, ADDR_W) +: ADDR_W];
                w_sel_wdata = bus.wdata[slice_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    // Compare one bit wider so DEPTH == 2**ADDR_W never wraps to zero.
    assign w_in_range = {1'b0, w_sel_addr} < DEPTH_EXT;
    assign w_idx      = w_sel_addr[IDX_W-1:0];

    // RAM array: not reset, writes to out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (w_any && w_sel_we && w_in_range) begin
            r_mem[w_idx] <= w_sel_wdata;
        end
    end

    // Response stage: one-cycle rvalid/err pulses, rdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= (w_any && !w_sel_we) ? w_gnt : '0;
            r_err    <= (w_any && !w_in_range) ? w_gnt : '0;
            if (w_any && !w_sel_we) begin
                r_rdata <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign bus.err    = r_err;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: directed vector table, reset-in-flight
// sequence, then randomized masters against a transaction-level model.
module tb_shared_ram_arbiter;

    localparam int NP    = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_ptr;

    always #5 clk = ~clk;

    shared_ram_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    shared_ram_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .o_dbg_ptr (dbg_ptr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Directed vectors: inputs for one cycle plus outputs expected in it.
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  rvalid;
        logic [3:0]  err;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] gnt, input logic [3:0] rvalid,
                                input logic [3:0] err, input logic [7:0] rdata);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.gnt = gnt; v.rvalid = rvalid; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    // Reference model state for the random phase.
    logic [7:0] m_mem [DEPTH];
    int         m_ptr;
    logic [3:0] m_rvalid;
    logic [3:0] m_err;
    logic [7:0] m_last;
    logic [7:0] exp_q[$];

    logic       p_act   [NP];
    logic       p_we    [NP];
    int         p_addr  [NP];
    logic [7:0] p_wdata [NP];

    task automatic rstep(input int load);
        int         k;
        logic [3:0] eg;
        logic [7:0] e;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (!p_act[p] && $urandom_range(0, 99) < load) begin
                p_act[p]   = 1'b1;
                p_we[p]    = 1'($urandom_range(0, 1));
                p_addr[p]  = $urandom_range(0, 255);
                p_wdata[p] = 8'($urandom);
            end
            bus.req[p]             = p_act[p];
            bus.we[p]              = p_we[p];
            bus.addr[p*AW +: AW]   = 8'(p_addr[p]);
            bus.wdata[p*DW +: DW]  = p_wdata[p];
        end
        k = -1;
        for (int j = 0; j < NP; j++) begin
            if (k < 0 && p_act[(m_ptr + j) % NP]) k = (m_ptr + j) % NP;
        end
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        @(negedge clk);
        check("rnd_ptr", 32'(dbg_ptr), 32'(m_ptr));
        check("rnd_gnt", 32'(bus.gnt), 32'(eg));
        check("rnd_rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        check("rnd_err", 32'(bus.err), 32'(m_err));
        if (m_rvalid != 4'b0) begin
            e = exp_q.pop_front();
            check("rnd_rdata", 32'(bus.rdata), 32'(e));
            m_last = e;
        end else begin
            check("rnd_rdata_hold", 32'(bus.rdata), 32'(m_last));
        end
        m_rvalid = '0;
        m_err    = '0;
        if (k >= 0) begin
            m_ptr = (k + 1) % NP;
            if (p_addr[k] >= DEPTH) m_err[k] = 1'b1;
            if (p_we[k]) begin
                if (p_addr[k] < DEPTH) m_mem[p_addr[k]] = p_wdata[k];
            end else begin
                m_rvalid[k] = 1'b1;
                exp_q.push_back(p_addr[k] < DEPTH ? m_mem[p_addr[k]] : 8'h00);
            end
            p_act[k] = 1'b0;
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req = req; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    endtask

    initial begin
        drive(4'hF, 4'h0, 32'h0, 32'h0);
        // Reset state, with every port requesting to prove gnt is forced low.
        #12;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_ptr", 32'(dbg_ptr), 32'h0);
        drive(4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //           req      we       addr           wdata          gnt      rvalid   err      rdata
        tbl.push_back(mk(4'b0001, 4'b0001, 32'h00000000, 32'h000000AA, 4'b0001, 4'b0000, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0001, 4'b0000, 32'h00000000, 32'h00000000, 4'b0001, 4'b0000, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0010, 4'b0010, 32'h00001000, 32'h0000BB00, 4'b0010, 4'b0001, 4'b0000, 8'hAA));
        tbl.push_back(mk(4'b0100, 4'b0100, 32'h00200000, 32'h00CC0000, 4'b0100, 4'b0000, 4'b0000, 8'hAA));
        tbl.push_back(mk(4'b1000, 4'b1000, 32'h30000000, 32'hDD000000, 4'b1000, 4'b0000, 4'b0000, 8'hAA));
        tbl.push_back(mk(4'b1111, 4'b0000, 32'h30201000, 32'h00000000, 4'b0001, 4'b0000, 4'b0000, 8'hAA));
        tbl.push_back(mk(4'b1110, 4'b0000, 32'h30201000, 32'h00000000, 4'b0010, 4'b0001, 4'b0000, 8'hAA));
        tbl.push_back(mk(4'b1100, 4'b0000, 32'h30201000, 32'h00000000, 4'b0100, 4'b0010, 4'b0000, 8'hBB));
        tbl.push_back(mk(4'b1000, 4'b0000, 32'h30201000, 32'h00000000, 4'b1000, 4'b0100, 4'b0000, 8'hCC));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 4'b1000, 4'b0000, 8'hDD));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 8'hDD));
        tbl.push_back(mk(4'b0100, 4'b0000, 32'h00200000, 32'h00000000, 4'b0100, 4'b0000, 4'b0000, 8'hDD));
        tbl.push_back(mk(4'b0100, 4'b0000, 32'h00200000, 32'h00000000, 4'b0100, 4'b0100, 4'b0000, 8'hCC));
        tbl.push_back(mk(4'b0110, 4'b0000, 32'h00201000, 32'h00000000, 4'b0010, 4'b0100, 4'b0000, 8'hCC));
        tbl.push_back(mk(4'b0110, 4'b0000, 32'h00201000, 32'h00000000, 4'b0100, 4'b0010, 4'b0000, 8'hBB));
        tbl.push_back(mk(4'b0110, 4'b0000, 32'h00201000, 32'h00000000, 4'b0010, 4'b0100, 4'b0000, 8'hCC));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 4'b0010, 4'b0000, 8'hBB));
        tbl.push_back(mk(4'b1000, 4'b1000, 32'h90000000, 32'h55000000, 4'b1000, 4'b0000, 4'b0000, 8'hBB));
        tbl.push_back(mk(4'b1000, 4'b0000, 32'h90000000, 32'h00000000, 4'b1000, 4'b0000, 4'b1000, 8'hBB));
        tbl.push_back(mk(4'b1000, 4'b0000, 32'h10000000, 32'h00000000, 4'b1000, 4'b1000, 4'b1000, 8'h00));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 4'b1000, 4'b0000, 8'hBB));
        tbl.push_back(mk(4'b0001, 4'b0001, 32'h00000040, 32'h00000011, 4'b0001, 4'b0000, 4'b0000, 8'hBB));
        tbl.push_back(mk(4'b0010, 4'b0000, 32'h00004000, 32'h00000000, 4'b0010, 4'b0000, 4'b0000, 8'hBB));
        tbl.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 4'b0010, 4'b0000, 8'h11));

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            check($sformatf("vec%0d_rvalid", i), 32'(bus.rvalid), 32'(tbl[i].rvalid));
            check($sformatf("vec%0d_err", i), 32'(bus.err), 32'(tbl[i].err));
            check($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].rdata));
        end

        // Reset right after a read grant: the pending response is cancelled.
        @(posedge clk);
        #1;
        drive(4'b0010, 4'b0000, 32'h00000000, 32'h0);
        @(negedge clk);
        check("mid_gnt", 32'(bus.gnt), 32'b0010);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(4'b1111, 4'b0000, 32'h00000000, 32'h0);
        #1;
        check("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("mid_rst_err", 32'(bus.err), 32'h0);
        check("mid_rst_rdata", 32'(bus.rdata), 32'h0);
        check("mid_rst_ptr", 32'(dbg_ptr), 32'h0);
        check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0011, 4'b0000, 32'h00000040, 32'h0);
        #1;
        check("post_rst_gnt0", 32'(bus.gnt), 32'b0001);
        @(posedge clk);
        #1;
        drive(4'b0010, 4'b0000, 32'h00000040, 32'h0);
        @(negedge clk);
        check("post_rst_gnt1", 32'(bus.gnt), 32'b0010);
        check("post_rst_rvalid0", 32'(bus.rvalid), 32'b0001);
        check("post_rst_rdata0", 32'(bus.rdata), 32'h11);
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        check("post_rst_rvalid1", 32'(bus.rvalid), 32'b0010);
        check("post_rst_rdata1", 32'(bus.rdata), 32'hAA);
        check("post_rst_ptr", 32'(dbg_ptr), 32'h2);

        // Random phase: fill every word first, then free-running masters.
        m_ptr    = 2;
        m_last   = 8'hAA;
        m_rvalid = '0;
        m_err    = '0;
        for (int p = 0; p < NP; p++) begin
            p_act[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 0; p_wdata[p] = 8'h00;
        end
        for (int a = 0; a < DEPTH; a++) begin
            p_act[a % NP]   = 1'b1;
            p_we[a % NP]    = 1'b1;
            p_addr[a % NP]  = a;
            p_wdata[a % NP] = 8'($urandom);
            rstep(0);
        end
        for (int c = 0; c < 500; c++) rstep(45);
        for (int c = 0; c < 8; c++) rstep(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
